// File: rtl/ml_ext_mem_bridge_if.sv
// Shared SoC memory bus: req/gnt request phase, rvalid/rdata response.
// master is the bridge side, slave is the memory/interconnect side.
interface ml_ext_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/ml_ext_mem_bridge.sv
// Accelerator ext_mem port to SoC bus bridge: posted writes, ordered reads, read timeout.
// Optional address window check enabled by defining MEM_BRIDGE_RANGE_CHK_EN.
module ml_ext_mem_bridge #(
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT  = 256,
    parameter logic [31:0] WIN_BASE    = 32'h8000_0000,
    parameter logic [31:0] WIN_SIZE    = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    input  logic        acc_we,
    input  logic        acc_re,
    output logic [31:0] acc_rdata,
    output logic        acc_ready,
    output logic        acc_err,
    input  logic        err_clr,
    ml_ext_mem_bridge_if.master mem
);

    typedef enum logic [2:0] {
        IDLE, WR_DRAIN, RD_REQ, RD_WAIT, RD_DONE
    } state_t;

    localparam int unsigned PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(WFIFO_DEPTH);
    localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RD_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [31:0]   f_addr [WFIFO_DEPTH];
    logic [31:0]   f_data [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   f_cnt;
    logic          f_full, f_empty;

    logic [31:2]   rd_addr;
    logic [CW-1:0] tmo_cnt;

    logic wr_acc, rd_acc, push, pop, wr_issue;
    logic in_win, rng_err, rsp_take, tmo_hit;

`ifdef MEM_BRIDGE_RANGE_CHK_EN
    logic [32:0] win_off;
    // A borrow out of the subtraction means the address is below the base.
    assign win_off = {1'b0, acc_addr} - {1'b0, WIN_BASE};
    assign in_win  = !win_off[32] && (win_off < {1'b0, WIN_SIZE});
`else
    logic unused_win;
    assign unused_win = ^{WIN_BASE, WIN_SIZE};
    assign in_win     = 1'b1;
`endif

    assign f_full  = (f_cnt == FULL_CNT);
    assign f_empty = (f_cnt == '0);

    assign wr_acc  = acc_ready && acc_we;
    assign rd_acc  = acc_ready && acc_re && !acc_we;
    assign push    = wr_acc && in_win;
    assign pop     = wr_issue && mem.bus_gnt;
    assign rng_err = (wr_acc || rd_acc) && !in_win;

    assign rsp_take = mem.bus_rvalid &&
                      ((state == RD_WAIT) ||
                       (state == RD_REQ && mem.bus_gnt));
    assign tmo_hit  = (state == RD_WAIT) && !mem.bus_rvalid &&
                      (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RD_DONE: begin
                state_nxt = IDLE;
                if (rd_acc) begin
                    if (!in_win)
                        state_nxt = RD_DONE;
                    else if (!f_empty)
                        state_nxt = WR_DRAIN;
                    else
                        state_nxt = RD_REQ;
                end
            end
            WR_DRAIN: begin
                if (f_empty || (pop && f_cnt == ONE_CNT))
                    state_nxt = RD_REQ;
            end
            RD_REQ: begin
                if (mem.bus_gnt)
                    state_nxt = mem.bus_rvalid ? RD_DONE : RD_WAIT;
            end
            RD_WAIT: begin
                if (rsp_take || tmo_hit)
                    state_nxt = RD_DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_ready     = 1'b0;
        wr_issue      = 1'b0;
        mem.bus_req   = 1'b0;
        mem.bus_we    = 1'b0;
        mem.bus_addr  = '0;
        mem.bus_wdata = '0;
        unique case (state)
            IDLE, RD_DONE: acc_ready = !f_full;
            RD_REQ: begin
                mem.bus_req  = 1'b1;
                mem.bus_addr = {rd_addr, 2'b00};
            end
            default: ;
        endcase
        // Reads own the bus once issued; writes drain in every other state.
        if (!f_empty && state != RD_REQ && state != RD_WAIT) begin
            wr_issue      = 1'b1;
            mem.bus_req   = 1'b1;
            mem.bus_we    = 1'b1;
            mem.bus_addr  = f_addr[rd_ptr];
            mem.bus_wdata = f_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
            for (int i = 0; i < int'(WFIFO_DEPTH); i++) begin
                f_addr[i] <= '0;
                f_data[i] <= '0;
            end
        end else begin
            if (push) begin
                f_addr[wr_ptr] <= {acc_addr[31:2], 2'b00};
                f_data[wr_ptr] <= acc_wdata;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            tmo_cnt   <= '0;
            acc_rdata <= '0;
            acc_err   <= 1'b0;
        end else begin
            if (rd_acc)
                rd_addr <= acc_addr[31:2];
            tmo_cnt <= (state == RD_WAIT) ? tmo_cnt + 1'b1 : '0;
            if (rsp_take)
                acc_rdata <= mem.bus_rdata;
            else if (tmo_hit)
                acc_rdata <= 32'hDEAD_BEEF;
            else if (rd_acc && !in_win)
                acc_rdata <= '0;
            // A new error outranks a simultaneous clear.
            acc_err <= tmo_hit || rng_err || (acc_err && !err_clr);
        end
    end

endmodule
